// File: rtl/led_sequencer_pkg.sv
// led_seq_pkg: shared types and sizing helper for the LED sequencer.
//   led_mode_t      - requested display pattern (OFF, BLINK, CHASE, BREATHE)
//   breathe_state_t - direction of the breathe duty ramp
//   cnt_w()         - bit width needed to hold an unsigned value up to max_val
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_t;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } breathe_state_t;

  // Never returns 0 so a degenerate counter still has a legal 1-bit vector.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// tick_gen: prescaler producing a registered one-cycle tick.
//   CLK   in  system clock
//   RST_N in  asynchronous active-low reset
//   clr   in  synchronous restart of the prescale period (drops a pending tick)
//   TICK  out high for the single cycle after the counter wraps
module tick_gen
  import led_seq_pkg::*;
#(
  parameter int unsigned PRESCALE = 12000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  output logic TICK
);

  localparam int unsigned CW = cnt_w(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          wrap;

  // PRESCALE=1 keeps the counter at 0, so wrap is constant and TICK stays high.
  assign wrap = (cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    tick_d = wrap;
    if (clr) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: drives N_LEDS outputs with one of four patterns.
//   CLK   in  system clock
//   RST_N in  asynchronous active-low reset
//   MODE  in  requested pattern (led_mode_t), sampled every cycle
//   LED   out registered LED drive, 1 = lit
//   TICK  out registered prescaler tick pulse
// A change of MODE restarts every pattern from its reset state; that restart
// wins over a tick landing in the same cycle.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned N_LEDS      = 5,
  parameter int unsigned PRESCALE    = 12000,
  parameter int unsigned BLINK_TICKS = 350,
  parameter int unsigned PWM_W       = 6
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  led_mode_t         MODE,
  output logic [N_LEDS-1:0] LED,
  output logic              TICK
);

  localparam int unsigned BW = cnt_w(BLINK_TICKS);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  led_mode_t      mode_q;
  logic           mode_chg;
  logic           tick;

  logic [BW-1:0]     blink_cnt_q, blink_cnt_d, blink_nxt;
  logic              phase_q, phase_d;
  logic [N_LEDS-1:0] chase_q, chase_d;
  logic [PWM_W-1:0]  duty_q, duty_d, duty_inc, duty_dec;
  breathe_state_t    bst_q, bst_d;
  logic [PWM_W-1:0]  pwm_q;
  logic [N_LEDS-1:0] led_q, led_d;

  assign mode_chg = (MODE != mode_q);

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (mode_chg),
    .TICK (tick)
  );

  assign blink_nxt = blink_cnt_q + 1'b1;
  assign duty_inc  = duty_q + 1'b1;
  assign duty_dec  = duty_q - 1'b1;

  // Pattern state. All patterns advance on every tick; only the one selected
  // by mode_q is shown, and entering a mode always starts it fresh.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    chase_d     = chase_q;
    duty_d      = duty_q;
    bst_d       = bst_q;
    if (mode_chg) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
      chase_d     = N_LEDS'(1);
      duty_d      = '0;
      bst_d       = RAMP_UP;
    end else if (tick) begin
      if (blink_nxt == BW'(BLINK_TICKS)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_nxt;
      end
      chase_d = {chase_q[N_LEDS-2:0], chase_q[N_LEDS-1]};
      // Direction flips on the tick that lands on an extreme, so the
      // extreme value is held for one tick only.
      case (bst_q)
        RAMP_UP: begin
          duty_d = duty_inc;
          if (duty_inc == DUTY_MAX) bst_d = RAMP_DOWN;
        end
        default: begin
          duty_d = duty_dec;
          if (duty_dec == '0) bst_d = RAMP_UP;
        end
      endcase
    end
  end

  always_comb begin
    case (mode_q)
      MODE_OFF:     led_d = '0;
      MODE_BLINK:   led_d = {N_LEDS{phase_q}};
      MODE_CHASE:   led_d = chase_q;
      MODE_BREATHE: led_d = {N_LEDS{pwm_q < duty_q}};
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      chase_q     <= N_LEDS'(1);
      duty_q      <= '0;
      bst_q       <= RAMP_UP;
      pwm_q       <= '0;
      led_q       <= '0;
    end else begin
      mode_q      <= MODE;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      chase_q     <= chase_d;
      duty_q      <= duty_d;
      bst_q       <= bst_d;
      pwm_q       <= pwm_q + 1'b1;
      led_q       <= led_d;
    end
  end

  assign LED  = led_q;
  assign TICK = tick;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: two instances share clock and reset.
//   u_a: PRESCALE=4, BLINK_TICKS=2, PWM_W=3
//   u_b: PRESCALE=1, BLINK_TICKS=2, PWM_W=3
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_led_sequencer;
  import led_seq_pkg::*;

  logic      clk   = 1'b0;
  logic      rst_n = 1'b0;
  led_mode_t mode_a = MODE_OFF;
  led_mode_t mode_b = MODE_OFF;
  logic [4:0] led_a, led_b;
  logic       tick_a, tick_b;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_sequencer #(.N_LEDS(5), .PRESCALE(4), .BLINK_TICKS(2), .PWM_W(3)) u_a (
    .CLK(clk), .RST_N(rst_n), .MODE(mode_a), .LED(led_a), .TICK(tick_a));

  led_sequencer #(.N_LEDS(5), .PRESCALE(1), .BLINK_TICKS(2), .PWM_W(3)) u_b (
    .CLK(clk), .RST_N(rst_n), .MODE(mode_b), .LED(led_b), .TICK(tick_b));

  // Duty after n ticks of a fresh breathe ramp at PWM_W=3: 0..7..1, period 14.
  function automatic int duty_of(input int n);
    int m;
    m = n % 14;
    return (m <= 7) ? m : 14 - m;
  endfunction

  // Expected breathe LED j edges after a reset released mid-cycle with
  // MODE=BREATHE: pwm after edge k is k%8, duty after edge k is duty_of(k-2).
  function automatic logic [4:0] breathe_exp(input int j);
    if (j <= 2) return 5'h00;
    return (((j - 1) % 8) < duty_of(j - 3)) ? 5'h1f : 5'h00;
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    mode_a = MODE_BLINK;
    mode_b = MODE_OFF;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (led_a !== 5'h00) begin errors++; $display("FAIL reset_led_a k=%0d got=%b exp=00000", k, led_a); end
      checks++;
      if (tick_a !== 1'b0) begin errors++; $display("FAIL reset_tick_a k=%0d got=%b exp=0", k, tick_a); end
      checks++;
      if (led_b !== 5'h00) begin errors++; $display("FAIL reset_led_b k=%0d got=%b exp=00000", k, led_b); end
    end
    // Release with MODE steady so the prescaler period is not restarted.
    mode_a = MODE_OFF;
    rst_n  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if (tick_a !== (k == 4)) begin errors++; $display("FAIL first_tick_a k=%0d got=%b exp=%b", k, tick_a, (k == 4)); end
      checks++;
      if (tick_b !== 1'b1) begin errors++; $display("FAIL tick_b_every_cycle k=%0d got=%b exp=1", k, tick_b); end
    end
  endtask

  task automatic test_blink();
    logic [4:0] exp;
    @(posedge clk); #1;
    mode_a = MODE_BLINK;
    for (int k = 1; k <= 27; k++) begin
      @(posedge clk); #1;
      exp = (k >= 3 && (((k - 3) / 8) % 2) == 1) ? 5'h1f : 5'h00;
      checks++;
      if (led_a !== exp) begin errors++; $display("FAIL blink k=%0d got=%b exp=%b", k, led_a, exp); end
      if (k == 4 || k == 5) begin
        checks++;
        if (tick_a !== (k == 5)) begin errors++; $display("FAIL blink_tick k=%0d got=%b exp=%b", k, tick_a, (k == 5)); end
      end
    end
  endtask

  task automatic test_chase_wrap();
    logic [4:0] exp_c [8] = '{5'h01, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h02};
    @(posedge clk); #1;
    mode_b = MODE_CHASE;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k >= 2) begin
        checks++;
        if (led_b !== exp_c[k-2]) begin errors++; $display("FAIL chase k=%0d got=%b exp=%b", k, led_b, exp_c[k-2]); end
      end
    end
  endtask

  // Switch CHASE->BLINK while TICK is high; the tick must not advance anything.
  task automatic test_mode_change();
    logic [4:0] exp;
    @(posedge clk); #1;
    mode_a = MODE_CHASE;
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk); #1;
      exp = 5'h00;
      if (k >= 2 && k <= 6) exp = 5'h01;
      else if (k >= 7 && k <= 10) exp = 5'h02;
      else if (k >= 20 && k <= 27) exp = 5'h1f;
      if (k >= 2) begin
        checks++;
        if (led_a !== exp) begin errors++; $display("FAIL mode_change k=%0d got=%b exp=%b", k, led_a, exp); end
      end
      if (k == 5 || k == 9 || k == 13 || k == 14) begin
        checks++;
        if (tick_a !== (k != 13)) begin errors++; $display("FAIL mode_change_tick k=%0d got=%b exp=%b", k, tick_a, (k != 13)); end
      end
      if (k == 9) mode_a = MODE_BLINK;
    end
  endtask

  task automatic test_breathe();
    @(posedge clk); #1;
    rst_n  = 1'b0;
    mode_b = MODE_BREATHE;
    #5 rst_n = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      @(posedge clk); #1;
      checks++;
      if (led_b !== breathe_exp(j)) begin errors++; $display("FAIL breathe j=%0d got=%b exp=%b", j, led_b, breathe_exp(j)); end
    end
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (led_b === 5'h1f) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL async_pre_lit got=%b exp=11111", led_b); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led_b !== 5'h00) begin errors++; $display("FAIL async_led_b got=%b exp=00000", led_b); end
    checks++;
    if (led_a !== 5'h00) begin errors++; $display("FAIL async_led_a got=%b exp=00000", led_a); end
    checks++;
    if (tick_b !== 1'b0) begin errors++; $display("FAIL async_tick_b got=%b exp=0", tick_b); end
    #2 rst_n = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      @(posedge clk); #1;
      checks++;
      if (led_b !== breathe_exp(j)) begin errors++; $display("FAIL async_breathe j=%0d got=%b exp=%b", j, led_b, breathe_exp(j)); end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_chase_wrap();
    test_mode_change();
    test_breathe();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
